// File: rtl/col_line_buffer_if.sv
// Pixel-in / column-vector-out stream bundle for col_line_buffer.
// The slave side is the line buffer; the master side is whatever feeds
// pixels and drains vectors (the column PE or a bench).
interface col_line_buffer_if #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_H = 7
);
  logic                               i_vld;
  logic                               i_eof;
  logic [DATA_W-1:0]                  i_data;
  logic                               o_rdy;
  logic                               i_rdy;
  logic                               o_vld;
  logic                               o_eof;
  logic [KERNEL_H-1:0][DATA_W-1:0]    o_data;

  modport slave (
    input  i_vld, i_eof, i_data, i_rdy,
    output o_rdy, o_vld, o_eof, o_data
  );

  modport master (
    output i_vld, i_eof, i_data, i_rdy,
    input  o_rdy, o_vld, o_eof, o_data
  );
endinterface

// File: rtl/col_line_buffer.sv
// Raster pixel stream to KERNEL_H-tall column vectors.
// KERNEL_H-1 line memories hold the previous rows; each accepted pixel is
// combined with the stored column to form a vector once the history is full.
// Output side is a single output register backed by one skid register.
module col_line_buffer #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_H = 7,
  parameter int IMG_W    = 32
)(
  input  logic              i_clk,
  input  logic              i_rst_n,
  col_line_buffer_if.slave  bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(KERNEL_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(KERNEL_H - 1);
  localparam logic [RW-1:0] ROW_PRE  = RW'(KERNEL_H - 2);

  localparam logic [0:0] S_FILL   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  typedef struct packed {
    logic                            eof;
    logic [KERNEL_H-1:0][DATA_W-1:0] data;
  } vec_t;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [0:0]        state;

  // mem[0] is the oldest row, mem[KERNEL_H-2] the row just above the current one
  logic [DATA_W-1:0] mem [KERNEL_H-1][IMG_W];

  vec_t new_vec;
  vec_t out_q, out_n;
  vec_t skid_q, skid_n;
  logic out_vld, out_vld_n;
  logic skid_vld, skid_vld_n;
  logic rdy_q;

  logic accept, emit, xfer;

  assign accept = bus.i_vld && rdy_q;
  assign emit   = accept && (state == S_STREAM);
  assign xfer   = out_vld && bus.i_rdy;

  // Column vector: stored history at the current column plus the live pixel on top
  always_comb begin
    new_vec     = '0;
    new_vec.eof = bus.i_eof;
    for (int k = 0; k < KERNEL_H - 1; k++)
      new_vec.data[k] = mem[k][col];
    new_vec.data[KERNEL_H-1] = bus.i_data;
  end

  // Raster position and fill/stream state; EOF restarts the frame on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col   <= '0;
      row   <= '0;
      state <= S_FILL;
    end else if (accept) begin
      if (bus.i_eof) begin
        col   <= '0;
        row   <= '0;
        state <= S_FILL;
      end else if (col == COL_LAST) begin
        col <= '0;
        if (row != ROW_LAST)
          row <= row + RW'(1);
        if (row == ROW_PRE)
          state <= S_STREAM;
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line memories shift one row up at the accepted column; contents are never reset
  // because the fill phase rewrites every entry before it can be emitted
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int j = 0; j < KERNEL_H - 2; j++)
        mem[j][col] <= mem[j+1][col];
      mem[KERNEL_H-2][col] <= bus.i_data;
    end
  end

  // Output/skid next state. A new vector only arrives while the skid is empty
  // (o_rdy guards it), so the skid never has to absorb two entries.
  always_comb begin
    out_n      = out_q;
    out_vld_n  = out_vld;
    skid_n     = skid_q;
    skid_vld_n = skid_vld;
    if (emit) begin
      if (!out_vld || xfer) begin
        out_n     = new_vec;
        out_vld_n = 1'b1;
      end else begin
        skid_n     = new_vec;
        skid_vld_n = 1'b1;
      end
    end else if (xfer) begin
      if (skid_vld) begin
        out_n      = skid_q;
        skid_vld_n = 1'b0;
      end else begin
        out_vld_n = 1'b0;
      end
    end
  end

  // Output registers. o_rdy drops on the edge that fills the skid and comes back
  // one cycle after it drains, so the upstream never sees ready with a full skid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      out_q    <= out_n;
      out_vld  <= out_vld_n;
      skid_q   <= skid_n;
      skid_vld <= skid_vld_n;
      rdy_q    <= !skid_vld && !skid_vld_n;
    end
  end

  assign bus.o_rdy  = rdy_q;
  assign bus.o_vld  = out_vld;
  assign bus.o_eof  = out_q.eof;
  assign bus.o_data = out_q.data;

endmodule

// File: doc/col_line_buffer.md
# col_line_buffer

Raster-order pixel-to-column-vector stage sitting directly upstream of the column convolution PE. Accepts one pixel per handshake, keeps the previous `KERNEL_H-1` image rows in line memories, and emits one `KERNEL_H`-tall column vector per accepted pixel once enough rows are buffered. Frame boundaries are carried on an end-of-file flag. Output uses the same valid/ready protocol the column PE consumes.

## Interface
- `DATA_W`, 8: pixel width in bits.
- `KERNEL_H`, 7: vector height. Legal range is 2..15.
- `IMG_W`, 32: fixed line width in pixels. Must be at least 2.
- `i_clk` input 1: the single clock.
- `i_rst_n` input 1: reset. Asynchronous and active-low.
- `i_vld` input 1: input pixel valid.
- `i_eof` input 1: the current pixel is the last pixel of the frame.
- `i_data` input `DATA_W`: input pixel, unsigned.
- `o_rdy` output 1: block can accept a pixel this cycle. Registered.
- `i_rdy` input 1: downstream can accept a vector.
- `o_vld` output 1: `o_data` and `o_eof` are valid.
- `o_eof` output 1: this vector contains the frame's last pixel.
- `o_data` output `[KERNEL_H-1:0][DATA_W-1:0]`: column vector. Element `k` holds the pixel from row `r-(KERNEL_H-1)+k` at the current column, so element `KERNEL_H-1` is the current pixel.

## Operation
**Counters**
- `col` counts 0..`IMG_W-1` and wraps to 0.
- `row` counts 0..`KERNEL_H-1` and saturates there.
- Both advance only on an accepted pixel. `row` increments when `col` wraps.

**Line memories**
- `KERNEL_H-1` register arrays, each `IMG_W`×`DATA_W`, read combinationally at `col`.
- On each accept at column `x`:
  - Form the vector from the stored entries plus the new pixel.
  - Write back shifted: `mem[j][x] <= mem[j+1][x]`, and the top array takes `i_data`.
- Memory contents are not reset. Stale data is never emitted, because of the fill rule below.

**States**
- FILL: `row < KERNEL_H-1`. Accepted pixels update memory and produce no output.
  - Transitions to STREAM when the pixel at `row==KERNEL_H-2`, `col==IMG_W-1` is accepted.
- STREAM: every accepted pixel produces one vector.
- On an accepted pixel with `i_eof=1`:
  - `col`, `row` and the state return to 0/FILL on the same edge.
  - In STREAM, the emitted vector carries `o_eof=1`.
  - In FILL, nothing is emitted and the partial frame is discarded.
  - `i_eof` on a pixel that is not accepted is ignored.

**Output buffering**
- One output register plus one skid register.
- `o_rdy` is registered: it is 1 when the skid register is empty.
- A vector is transferred when `o_vld && i_rdy`.
- Output order equals input order. No vector is dropped or duplicated under any `i_rdy` pattern.

**Reset (`i_rst_n` low, takes effect immediately)**
- Outputs: `o_vld=0`, `o_eof=0`, `o_data=0`, `o_rdy=0`.
- Internal: `col=0`, `row=0`, state FILL, skid register empty.
- `o_rdy` rises on the first clock edge after deassertion.
- Reset mid-frame discards all buffered vectors and the row history.

## Timing
- Latency is 1 cycle. A pixel accepted at edge N drives `o_vld=1` with its vector after edge N, as long as the output register is free or being drained at N.
- Throughput is 1 vector/cycle with `i_rdy` held at 1. `o_rdy` stays 1 continuously.
- Backpressure:
  - While `o_vld && !i_rdy`, `o_data`/`o_eof`/`o_vld` hold stable.
  - One further pixel may be accepted into the skid register. `o_rdy` falls on the next edge.
- When `i_rdy` returns:
  - The skid entry moves to the output register on the following transfer.
  - `o_rdy` rises one cycle after the skid register empties.
- Simultaneous transfer out and accept in with the skid register empty: the new vector replaces the output register and `o_vld` stays 1.
- Pixels accepted in FILL never affect `o_vld`.

## Test plan
Benches use `KERNEL_H=3`, `IMG_W=4`, pixel value = `row*16+col`.
- **Reset:** assert `i_rst_n=0` mid-stream → all outputs 0 immediately; `o_rdy=1` one edge after release; the next 8 pixels produce no `o_vld`.
- **Fill and stream:** 3 rows streamed with `i_rdy=1`.
  - No output for the first 8 pixels.
  - Pixel (2,0) produces `o_data={32,16,0}` (element2..element0) one cycle later.
  - Pixel (2,3) produces `{35,19,3}`.
- **Row wrap:** 4 rows → row 3 vectors are `{48+c,32+c,16+c}` for c=0..3, confirming the history shift.
- **Backpressure:** `i_rdy` random at 30% duty over 5 rows → the output sequence is identical to the `i_rdy=1` run; `o_data` is stable whenever `o_vld && !i_rdy`; `o_rdy` is never 1 while the skid register is full.
- **EOF in STREAM:** `i_eof` on pixel (2,3) → that vector has `o_eof=1`; the next frame's first 8 pixels emit nothing.
- **EOF in FILL:** `i_eof` on pixel (1,1) → no vector is emitted; the following full frame produces vectors only from its own rows.
